fixed_matrix_tile_streamer: RTL and testbench

//  Producer side of the matrix-multiply data/weight stream. Takes an N x K operand arriving row-major, COL_PAR elements per beat.

---
 rtl/fixed_matrix_stream_pkg.sv | 24 ++
 rtl/fixed_matrix_tile_bank.sv | 51 +++++
 rtl/fixed_matrix_tile_streamer.sv | 246 ++++++++++++++++++++++++
 tb/tb_fixed_matrix_tile_streamer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_matrix_stream_pkg.sv
// ---------------------------------------------------------------------------
// fixed_matrix_stream_pkg
//   Shared types and elaboration-time helpers for the matrix tile streamer.
//   - state_t      : FILL / DRAIN state of the single-bank streamer
//   - cnt_width()  : counter width for a modulo-n counter (at least 1 bit)
//   - block_beats(): number of input beats that make up one row block
// ---------------------------------------------------------------------------
package fixed_matrix_stream_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // A modulo-1 counter still needs one bit so every port stays non-empty.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int block_beats(input int row_par, input int depth);
        return row_par * depth;
    endfunction

endpackage

// File: rtl/fixed_matrix_tile_bank.sv
// ---------------------------------------------------------------------------
// fixed_matrix_tile_bank
//   Register storage for one row block: ROW_PAR rows x DEPTH segments, each
//   segment COL_PAR elements wide. One synchronous write port addressed by
//   (row, seg) and one combinational read port that returns the whole tile
//   for a segment, i.e. segment seg of every row.
//   Contents are deliberately not reset.
// Ports
//   clk_i      in   clock
//   wr_en_i    in   write strobe
//   wr_row_i   in   row index of the written segment
//   wr_seg_i   in   segment index of the written segment
//   wr_data_i  in   COL_PAR elements to store
//   rd_seg_i   in   segment index of the tile to read
//   rd_tile_o  out  tile, rd_tile_o[r][c] = row r, column rd_seg_i*COL_PAR+c
// ---------------------------------------------------------------------------
module fixed_matrix_tile_bank
    import fixed_matrix_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_PAR    = 4,
    parameter int COL_PAR    = 3,
    parameter int DEPTH      = 3,
    localparam int ROW_W     = cnt_width(ROW_PAR),
    localparam int SEG_W     = cnt_width(DEPTH)
) (
    input  logic                                           clk_i,
    input  logic                                           wr_en_i,
    input  logic [ROW_W-1:0]                               wr_row_i,
    input  logic [SEG_W-1:0]                               wr_seg_i,
    input  logic [COL_PAR-1:0][DATA_WIDTH-1:0]             wr_data_i,
    input  logic [SEG_W-1:0]                               rd_seg_i,
    output logic [ROW_PAR-1:0][COL_PAR-1:0][DATA_WIDTH-1:0] rd_tile_o
);

    logic [COL_PAR-1:0][DATA_WIDTH-1:0] mem_q [ROW_PAR][DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_row_i][wr_seg_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_tile_o = '0;
        for (int r = 0; r < ROW_PAR; r++) begin
            rd_tile_o[r] = mem_q[r][rd_seg_i];
        end
    end

endmodule

// File: rtl/fixed_matrix_tile_streamer.sv
// ---------------------------------------------------------------------------
// fixed_matrix_tile_streamer
//   Producer side of the matrix-multiply operand stream. Accepts an operand
//   row-major, COL_PAR elements per beat, buffers one block of ROW_PAR rows
//   (DEPTH segments per row) and re-emits it as DEPTH tiles of
//   ROW_PAR x COL_PAR, NUM_REPEAT times over.
//
//   Handshake: a beat moves on a port in a cycle where valid && ready is
//   sampled high at the rising clock edge. A raised data_out_valid stays high
//   with data_out/data_out_last bit-stable until that handshake happens.
//
//   Build option FIXED_MATRIX_TILE_STREAMER_PINGPONG_EN: two banks, so the
//   next block fills while the current one drains. Without it a single bank
//   alternates between FILL and DRAIN.
// Ports
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-low reset
//   data_in         in   row segment, data_in[c] = column seg*COL_PAR+c
//   data_in_valid   in   input beat valid
//   data_in_ready   out  input beat accepted when valid && ready
//   data_out        out  tile, data_out[r*COL_PAR+c] = row r, col seg*COL_PAR+c
//   data_out_valid  out  tile valid
//   data_out_ready  in   tile consumed when valid && ready
//   data_out_last   out  last tile of the last repeat of a block
//   dbg_state_o     out  DRAIN while a buffered block is being emitted
// ---------------------------------------------------------------------------
module fixed_matrix_tile_streamer
    import fixed_matrix_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_PAR    = 4,
    parameter int COL_PAR    = 3,
    parameter int DEPTH      = 3,
    parameter int NUM_REPEAT = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [COL_PAR-1:0][DATA_WIDTH-1:0]           data_in,
    input  logic                                         data_in_valid,
    output logic                                         data_in_ready,
    output logic [ROW_PAR*COL_PAR-1:0][DATA_WIDTH-1:0]   data_out,
    output logic                                         data_out_valid,
    input  logic                                         data_out_ready,
    output logic                                         data_out_last,
    output state_t                                       dbg_state_o
);

    localparam int BLOCK_BEATS = block_beats(ROW_PAR, DEPTH);
    localparam int BEAT_W      = cnt_width(BLOCK_BEATS);
    localparam int ROW_W       = cnt_width(ROW_PAR);
    localparam int SEG_W       = cnt_width(DEPTH);
    localparam int REP_W       = cnt_width(NUM_REPEAT);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_BEATS - 1);
    localparam logic [SEG_W-1:0]  SEG_LAST  = SEG_W'(DEPTH - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(NUM_REPEAT - 1);

    logic [ROW_W-1:0]  in_row_q;
    logic [SEG_W-1:0]  in_seg_q;
    logic [SEG_W-1:0]  out_seg_q;
    logic [REP_W-1:0]  rep_q;
    logic [BEAT_W-1:0] in_beat_idx;

    logic in_fire;
    logic out_fire;
    logic in_last_beat;
    logic out_last_seg;
    logic out_last_rep;

    assign in_fire      = data_in_valid && data_in_ready;
    assign out_fire     = data_out_valid && data_out_ready;
    // Beat number within the block: row*DEPTH + seg.
    assign in_beat_idx  = BEAT_W'(in_row_q) * BEAT_W'(DEPTH) + BEAT_W'(in_seg_q);
    assign in_last_beat = (in_beat_idx == BEAT_LAST);
    assign out_last_seg = (out_seg_q == SEG_LAST);
    assign out_last_rep = (rep_q == REP_LAST);

    // Write (in_row, in_seg) and read (out_seg, rep) position counters. They
    // only move on their own handshake, so backpressure freezes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_row_q  <= '0;
            in_seg_q  <= '0;
            out_seg_q <= '0;
            rep_q     <= '0;
        end else begin
            if (in_fire) begin
                if (in_seg_q == SEG_LAST) begin
                    in_seg_q <= '0;
                    in_row_q <= in_last_beat ? '0 : in_row_q + 1'b1;
                end else begin
                    in_seg_q <= in_seg_q + 1'b1;
                end
            end
            if (out_fire) begin
                if (out_last_seg) begin
                    out_seg_q <= '0;
                    rep_q     <= out_last_rep ? '0 : rep_q + 1'b1;
                end else begin
                    out_seg_q <= out_seg_q + 1'b1;
                end
            end
        end
    end

`ifdef FIXED_MATRIX_TILE_STREAMER_PINGPONG_EN

    logic [1:0] full_q;
    logic [1:0] full_d;
    logic [1:0] full_set;
    logic [1:0] full_clr;
    logic       wr_bank_q;
    logic       rd_bank_q;
    logic       rdy_en_q;
    logic [ROW_PAR-1:0][COL_PAR-1:0][DATA_WIDTH-1:0] rd_tile [2];

    // Set and clear always target different banks (a bank being filled is
    // never full, a bank being drained always is), so both may apply at once.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (in_fire && in_last_beat) begin
            full_set[wr_bank_q] = 1'b1;
        end
        if (out_fire && out_last_seg && out_last_rep) begin
            full_clr[rd_bank_q] = 1'b1;
        end
        full_d = (full_q | full_set) & ~full_clr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            full_q   <= full_d;
            rdy_en_q <= 1'b1;
            if (|full_set) begin
                wr_bank_q <= ~wr_bank_q;
            end
            if (|full_clr) begin
                rd_bank_q <= ~rd_bank_q;
            end
        end
    end

    // rdy_en_q keeps ready low through reset and the cycle it is released in.
    assign data_in_ready  = rdy_en_q && !full_q[wr_bank_q];
    assign data_out_valid = full_q[rd_bank_q];
    assign data_out_last  = data_out_valid && out_last_seg && out_last_rep;
    assign data_out       = rd_tile[rd_bank_q];
    assign dbg_state_o    = data_out_valid ? DRAIN : FILL;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fixed_matrix_tile_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ROW_PAR    (ROW_PAR),
            .COL_PAR    (COL_PAR),
            .DEPTH      (DEPTH)
        ) u_bank (
            .clk_i     (clk),
            .wr_en_i   (in_fire && (wr_bank_q == 1'(b))),
            .wr_row_i  (in_row_q),
            .wr_seg_i  (in_seg_q),
            .wr_data_i (data_in),
            .rd_seg_i  (out_seg_q),
            .rd_tile_o (rd_tile[b])
        );
    end

`else

    state_t state_q;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   out_last_q;
    logic [ROW_PAR-1:0][COL_PAR-1:0][DATA_WIDTH-1:0] rd_tile;

    // Outputs are registered: each branch computes what they must be for
    // the counter values that take effect on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (in_fire && in_last_beat) begin
                        state_q     <= DRAIN;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        // First tile is seg 0 of repeat 0.
                        out_last_q  <= (DEPTH == 1) && (NUM_REPEAT == 1);
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (out_last_seg && out_last_rep) begin
                            state_q     <= FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else if (out_last_seg) begin
                            out_last_q <= (DEPTH == 1) &&
                                          (REP_W'(rep_q + 1'b1) == REP_LAST);
                        end else begin
                            out_last_q <= out_last_rep &&
                                          (SEG_W'(out_seg_q + 1'b1) == SEG_LAST);
                        end
                    end
                end
            endcase
        end
    end

    assign data_in_ready  = in_ready_q;
    assign data_out_valid = out_valid_q;
    assign data_out_last  = out_last_q;
    assign data_out       = rd_tile;
    assign dbg_state_o    = state_q;

    // The bank is only written in FILL, so the tile read during DRAIN is
    // stable while the consumer stalls.
    fixed_matrix_tile_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_PAR    (ROW_PAR),
        .COL_PAR    (COL_PAR),
        .DEPTH      (DEPTH)
    ) u_bank (
        .clk_i     (clk),
        .wr_en_i   (in_fire),
        .wr_row_i  (in_row_q),
        .wr_seg_i  (in_seg_q),
        .wr_data_i (data_in),
        .rd_seg_i  (out_seg_q),
        .rd_tile_o (rd_tile)
    );

`endif

endmodule

// File: tb/tb_fixed_matrix_tile_streamer.sv
// ---------------------------------------------------------------------------
// tb_fixed_matrix_tile_streamer
//   Directed bench for two streamers (NUM_REPEAT = 1 and NUM_REPEAT = 2) with
//   DATA_WIDTH=8, ROW_PAR=2, COL_PAR=2, DEPTH=3. A block-level model predicts
//   readiness and the expected tile stream; the compare process checks every
//   cycle, and the directed sequences pin literal tile values.
// ---------------------------------------------------------------------------
module tb_fixed_matrix_tile_streamer;
    import fixed_matrix_stream_pkg::*;

    localparam int DW = 8;
    localparam int RP = 2;
    localparam int CP = 2;
    localparam int DP = 3;
    localparam int NB = RP * DP;
    localparam int TW = RP * CP * DW;
`ifdef FIXED_MATRIX_TILE_STREAMER_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic                   din_valid  [2];
    logic [CP-1:0][DW-1:0]  din        [2];
    logic                   din_ready  [2];
    logic [RP*CP-1:0][DW-1:0] dout     [2];
    logic                   dout_valid [2];
    logic                   dout_ready [2];
    logic                   dout_last  [2];
    state_t                 dbg        [2];

    fixed_matrix_tile_streamer #(
        .DATA_WIDTH(DW), .ROW_PAR(RP), .COL_PAR(CP), .DEPTH(DP), .NUM_REPEAT(1)
    ) dut (
        .clk(clk), .rst(rst_n),
        .data_in(din[0]), .data_in_valid(din_valid[0]), .data_in_ready(din_ready[0]),
        .data_out(dout[0]), .data_out_valid(dout_valid[0]), .data_out_ready(dout_ready[0]),
        .data_out_last(dout_last[0]), .dbg_state_o(dbg[0])
    );

    fixed_matrix_tile_streamer #(
        .DATA_WIDTH(DW), .ROW_PAR(RP), .COL_PAR(CP), .DEPTH(DP), .NUM_REPEAT(2)
    ) dut_rep2 (
        .clk(clk), .rst(rst_n),
        .data_in(din[1]), .data_in_valid(din_valid[1]), .data_in_ready(din_ready[1]),
        .data_out(dout[1]), .data_out_valid(dout_valid[1]), .data_out_ready(dout_ready[1]),
        .data_out_last(dout_last[1]), .dbg_state_o(dbg[1])
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;

    bit             started     [2];
    int             nbeats      [2];
    int             outstanding [2];
    logic [CP*DW-1:0] beats     [2][NB];
    logic [TW:0]    exp_q       [2][$];   // {last, tile}

    function automatic int reps_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    // Tile s of the buffered block: element r*CP+c is row r, column s*CP+c.
    function automatic logic [TW-1:0] tile_of(input int d, input int s);
        logic [TW-1:0] t;
        t = '0;
        for (int r = 0; r < RP; r++)
            for (int c = 0; c < CP; c++)
                t[(r*CP+c)*DW +: DW] = beats[d][r*DP+s][c*DW +: DW];
        return t;
    endfunction

    function automatic logic [TW-1:0] tl(input int a, input int b, input int c, input int e);
        return {DW'(e), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic bit model_ready(input int d);
        return started[d] && (outstanding[d] < CAP);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                started[d] = 1'b0;
                nbeats[d] = 0;
                outstanding[d] = 0;
                exp_q[d].delete();
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit rdy;
                logic [TW:0] head;
                rdy = model_ready(d);
                if (exp_q[d].size() > 0 && dout_ready[d]) begin
                    head = exp_q[d].pop_front();
                    if (head[TW]) outstanding[d]--;
                end
                if (din_valid[d] && rdy) begin
                    beats[d][nbeats[d]] = din[d];
                    nbeats[d]++;
                    if (nbeats[d] == NB) begin
                        for (int k = 0; k < reps_of(d); k++)
                            for (int s = 0; s < DP; s++)
                                exp_q[d].push_back({(k == reps_of(d)-1) && (s == DP-1), tile_of(d, s)});
                        outstanding[d]++;
                        nbeats[d] = 0;
                    end
                end
                started[d] = 1'b1;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("cyc in_ready[%0d]", d), din_ready[d], model_ready(d));
            check($sformatf("cyc out_valid[%0d]", d), dout_valid[d], exp_q[d].size() > 0);
            if (exp_q[d].size() > 0 && dout_valid[d]) begin
                check($sformatf("cyc tile[%0d]", d), dout[d], exp_q[d][0][TW-1:0]);
                check($sformatf("cyc last[%0d]", d), dout_last[d], exp_q[d][0][TW]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Beat i carries elements {first+2i, first+2i+1}.
    task automatic send_beats(input int d, input int n, input int first);
        for (int i = 0; i < n; i++) begin
            int budget;
            bit acc;
            budget = 0;
            acc = 1'b0;
            din_valid[d] = 1'b1;
            din[d][0] = DW'(first + 2*i);
            din[d][1] = DW'(first + 2*i + 1);
            while (!acc && budget < 200) begin
                acc = din_ready[d];
                step();
                budget++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL send_beat[%0d]: beat %0d not accepted, got timeout required ready", d, i);
            end
        end
        din_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int budget;
        budget = 0;
        while (dout_valid[d] && budget < 200) begin
            step();
            budget++;
        end
        checks++;
        if (dout_valid[d]) begin
            errors++;
            $display("FAIL wait_idle[%0d]: got valid=1 after %0d cycles required 0", d, budget);
        end
    endtask

    task automatic expect_tile(input string name, input int d, input logic [TW-1:0] t, input bit last);
        check({name, " valid"}, dout_valid[d], 1);
        check({name, " tile"}, dout[d], t);
        check({name, " last"}, dout_last[d], last);
`ifndef FIXED_MATRIX_TILE_STREAMER_PINGPONG_EN
        check({name, " in_ready"}, din_ready[d], 0);
`endif
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        logic [TW-1:0] seq [3];
        int c0;
        for (int d = 0; d < 2; d++) begin
            din_valid[d] = 1'b0;
            din[d] = '0;
            dout_ready[d] = 1'b1;
        end
        seq[0] = tl(1, 2, 7, 8);
        seq[1] = tl(3, 4, 9, 10);
        seq[2] = tl(5, 6, 11, 12);

        rst_n = 1'b0;
        step();
        step();
        check("reset in_ready", din_ready[0], 0);
        check("reset valid", dout_valid[0], 0);
        check("reset last", dout_last[0], 0);
        check("reset state", dbg[0], FILL);
        rst_n = 1'b1;
        step();
        check("ready after release", din_ready[0], 1);

        // 1: plain block, continuous ready
        send_beats(0, NB, 1);
        expect_tile("t1 tile0", 0, seq[0], 0);
`ifndef FIXED_MATRIX_TILE_STREAMER_PINGPONG_EN
        check("t1 state drain", dbg[0], DRAIN);
`endif
        step();
        expect_tile("t1 tile1", 0, seq[1], 0);
        step();
        expect_tile("t1 tile2", 0, seq[2], 1);
        step();
        check("t1 idle valid", dout_valid[0], 0);
        check("t1 idle in_ready", din_ready[0], 1);

        // 2: consumer stalls 5 cycles on tile 1
        send_beats(0, NB, 1);
        expect_tile("t2 tile0", 0, seq[0], 0);
        step();
        dout_ready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            expect_tile("t2 held tile1", 0, seq[1], 0);
        end
        dout_ready[0] = 1'b1;
        step();
        expect_tile("t2 tile2", 0, seq[2], 1);
        step();
        check("t2 idle valid", dout_valid[0], 0);

        // 3: NUM_REPEAT=2 emits the sequence twice
        send_beats(1, NB, 1);
        for (int k = 0; k < 2*DP; k++) begin
            expect_tile($sformatf("t3 tile%0d", k), 1, seq[k % DP], k == 2*DP-1);
            step();
        end
        check("t3 idle valid", dout_valid[1], 0);
        check("t3 fill resumes", din_ready[1], 1);

        // 4: reset mid-fill discards the partial block
        send_beats(0, 4, 41);
        rst_n = 1'b0;
        #1;
        check("t4 reset valid", dout_valid[0], 0);
        check("t4 reset in_ready", din_ready[0], 0);
        step();
        check("t4 reset held in_ready", din_ready[0], 0);
        rst_n = 1'b1;
        send_beats(0, NB, 21);
        expect_tile("t4 tile0", 0, tl(21, 22, 27, 28), 0);
        step();
        expect_tile("t4 tile1", 0, tl(23, 24, 29, 30), 0);
        step();
        expect_tile("t4 tile2", 0, tl(25, 26, 31, 32), 1);
        step();
        wait_idle(0);

`ifdef FIXED_MATRIX_TILE_STREAMER_PINGPONG_EN
        // 5: two blocks back to back, no input bubbles
        c0 = cyc;
        send_beats(0, 2*NB, 1);
        check("t5 input cycles", cyc - c0, 2*NB);
        check("t5 block2 tile0", dout[0], tl(13, 14, 19, 20));
        step();
        step();
        check("t5 block2 last", dout_last[0], 1);
        check("t5 block2 tile2", dout[0], tl(17, 18, 23, 24));
        step();
        wait_idle(0);

        // 6: last fill of bank 1 coincides with last drain of bank 0
        dout_ready[0] = 1'b0;
        send_beats(0, NB, 1);
        send_beats(0, 3, 41);
        dout_ready[0] = 1'b1;
        send_beats(0, 3, 47);
        check("t6 no gap valid", dout_valid[0], 1);
        check("t6 bank1 tile0", dout[0], tl(41, 42, 47, 48));
        check("t6 bank1 last", dout_last[0], 0);
        check("t6 bank0 free", din_ready[0], 1);
        step();
        check("t6 bank1 tile1", dout[0], tl(43, 44, 49, 50));
        step();
        check("t6 bank1 tile2", dout[0], tl(45, 46, 51, 52));
        check("t6 bank1 tile2 last", dout_last[0], 1);
        step();
        wait_idle(0);
`else
        c0 = cyc;
        check("idle stays idle", dout_valid[0], 0);
        step();
        check("idle cycle count", cyc - c0, 1);
`endif

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
